risc_v_lsu_sequencer: RTL and testbench

Multi-cycle load/store sequencer between the decode/control stage and a handshaked data memory. It turns the decoder's load/store strobes and funct3 into one bus transaction: word address, byte strobes, and lane-replicated store data. It formats load data with sign or zero extension and stalls the core until the access completes, faults, or times out.

---
 rtl/risc_v_lsu_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_risc_v_lsu_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_v_lsu_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// risc_v_lsu_sequencer
//
// Multi-cycle load/store sequencer sitting between decode/control and a
// handshaked data memory. A decoded memory instruction becomes one bus
// transaction (word address, byte strobes, lane-replicated store data). Load
// data is sign/zero extended, and the core is stalled until the access
// completes, faults (illegal or misaligned) or times out.
//
// Ports
//   clk, rst_n          core clock (rising edge), async active-low reset
//   start               decoded memory instruction valid this cycle
//   is_load, is_store   decoder access type
//   funct3              access size / sign field
//   addr, wdata         effective byte address, store source (rs2)
//   stall               freeze PC/pipeline (combinational)
//   done, fault         one-cycle completion / fault pulses
//   fault_code          0 none, 1 misaligned, 2 illegal, 3 timeout
//   load_data           extended load result, valid with done
//   mem_req, mem_we     bus request / write enable
//   mem_addr            word-aligned bus address
//   mem_wstrb           byte lane enables (0 on reads)
//   mem_wdata           lane-replicated store data
//   mem_ack, mem_rdata  single-cycle accept/complete and read word
// ---------------------------------------------------------------------------
module risc_v_lsu_sequencer #(
    parameter int WORD_LENGTH = 32,
    parameter int TIMEOUT     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   is_load,
    input  logic                   is_store,
    input  logic [2:0]             funct3,
    input  logic [WORD_LENGTH-1:0] addr,
    input  logic [WORD_LENGTH-1:0] wdata,
    output logic                   stall,
    output logic                   done,
    output logic                   fault,
    output logic [1:0]             fault_code,
    output logic [WORD_LENGTH-1:0] load_data,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [WORD_LENGTH-1:0] mem_addr,
    output logic [3:0]             mem_wstrb,
    output logic [WORD_LENGTH-1:0] mem_wdata,
    input  logic                   mem_ack,
    input  logic [WORD_LENGTH-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE,
        S_FAULT
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             fault_code_q, fault_code_d;
    logic [WORD_LENGTH-1:0] load_data_q, load_data_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [WORD_LENGTH-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]             mem_wstrb_q, mem_wstrb_d;
    logic [WORD_LENGTH-1:0] mem_wdata_q, mem_wdata_d;

    // Access attributes latched at start, needed again when the read returns.
    logic [2:0]             f3_q;
    logic                   is_load_q;
    logic [1:0]             off_q;

    logic                   illegal;
    logic                   misaligned;

    // Byte lane enables for a store of the given size at byte offset off.
    function automatic logic [3:0] byte_strobe(input logic [2:0] f3,
                                               input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the store operand across all lanes so the strobes alone
    // select which bytes memory updates.
    function automatic logic [WORD_LENGTH-1:0] replicate(input logic [2:0] f3,
                                                         input logic [WORD_LENGTH-1:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Pick the addressed byte/half out of the read word and extend it.
    function automatic logic [WORD_LENGTH-1:0] format_load(input logic [2:0] f3,
                                                           input logic [1:0] off,
                                                           input logic [WORD_LENGTH-1:0] rd);
        logic        [7:0]             ub;
        logic        [15:0]            uh;
        logic signed [7:0]             sb;
        logic signed [15:0]            sh;
        logic signed [WORD_LENGTH-1:0] ext;
        ub  = rd[8*off +: 8];
        uh  = rd[16*off[1] +: 16];
        sb  = ub;
        sh  = uh;
        ext = '0;
        case (f3)
            3'b000:  ext = sb;
            3'b001:  ext = sh;
            3'b100:  ext = {{(WORD_LENGTH-8){1'b0}}, ub};
            3'b101:  ext = {{(WORD_LENGTH-16){1'b0}}, uh};
            default: ext = rd;
        endcase
        return $unsigned(ext);
    endfunction

    // Decode checks on the live decoder inputs (only consulted in IDLE).
    always_comb begin
        illegal    = (is_load == is_store)
                   || (is_load  && (funct3 == 3'b011 || funct3[2:1] == 2'b11))
                   || (is_store && (funct3[2] || funct3[1:0] == 2'b11));
        misaligned = (funct3[1:0] == 2'b01 && addr[0])
                   || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fault_code_d = fault_code_q;
        load_data_d  = load_data_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    fault_code_d = 2'd0;
                    if (illegal) begin
                        fault_code_d = 2'd2;
                        state_d      = S_FAULT;
                    end else if (misaligned) begin
                        fault_code_d = 2'd1;
                        state_d      = S_FAULT;
                    end else begin
                        state_d     = S_REQ;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {addr[WORD_LENGTH-1:2], 2'b00};
                        mem_wstrb_d = is_store ? byte_strobe(funct3, addr[1:0]) : 4'b0000;
                        mem_wdata_d = replicate(funct3, wdata);
                    end
                end
            end

            S_REQ: begin
                if (mem_ack || cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Leaving REQ either way: release the bus next cycle.
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wstrb_d = 4'b0000;
                    mem_wdata_d = '0;
                    if (mem_ack) begin
                        state_d     = S_DONE;
                        load_data_d = is_load_q ? format_load(f3_q, off_q, mem_rdata) : '0;
                    end else begin
                        state_d      = S_FAULT;
                        fault_code_d = 2'd3;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            fault_code_q <= 2'd0;
            load_data_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wstrb_q  <= 4'b0000;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fault_code_q <= fault_code_d;
            load_data_q  <= load_data_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Pure datapath capture; only read back while a transaction is in flight.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && start) begin
            f3_q      <= funct3;
            is_load_q <= is_load;
            off_q     <= addr[1:0];
        end
    end

    assign stall      = (state_q == S_IDLE && start) || (state_q == S_REQ);
    assign done       = (state_q == S_DONE);
    assign fault      = (state_q == S_FAULT);
    assign fault_code = fault_code_q;
    assign load_data  = load_data_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_risc_v_lsu_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_risc_v_lsu_sequencer
//
// Scoreboard bench: each issued instruction pushes its expected bus request
// and response into a queue; an independent monitor compares the bus while
// mem_req is high and pops/compares on every done or fault pulse. The
// expected values come from a byte-level behavioural model.
// ---------------------------------------------------------------------------
module tb_risc_v_lsu_sequencer;

    localparam int WL = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          is_load = 1'b0;
    logic          is_store = 1'b0;
    logic [2:0]    funct3 = 3'd0;
    logic [WL-1:0] addr = '0;
    logic [WL-1:0] wdata = '0;
    logic          stall;
    logic          done;
    logic          fault;
    logic [1:0]    fault_code;
    logic [WL-1:0] load_data;
    logic          mem_req;
    logic          mem_we;
    logic [WL-1:0] mem_addr;
    logic [3:0]    mem_wstrb;
    logic [WL-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [WL-1:0] mem_rdata = '0;

    risc_v_lsu_sequencer #(.WORD_LENGTH(WL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load),
        .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .fault(fault), .fault_code(fault_code),
        .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_fault;
        logic [1:0]  code;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wd;
        logic [31:0] ld;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] model_ld = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte-level reference: access size in bytes, alignment by modulo,
    // lanes filled by repeating the source bytes, loads via shift/mask and
    // two's-complement adjustment.
    function automatic exp_t model(input bit ld, input bit st, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] rd, input bit to,
                                   input logic [31:0] cur);
        exp_t        e;
        int          size;
        int          off;
        bit          ok;
        logic [63:0] v;
        e.is_fault = 1'b0;
        e.code     = 2'd0;
        e.we       = st;
        e.addr     = a & 32'hFFFF_FFFC;
        e.strb     = 4'b0000;
        e.wd       = '0;
        e.ld       = cur;
        off  = int'(a[1:0]);
        size = 1 << f3[1:0];
        ok   = (ld && !st && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
            || (st && !ld && (f3 inside {3'd0, 3'd1, 3'd2}));
        if (!ok) begin
            e.is_fault = 1'b1;
            e.code     = 2'd2;
        end else if (off % size != 0) begin
            e.is_fault = 1'b1;
            e.code     = 2'd1;
        end else begin
            if (st) begin
                e.strb = 4'(((1 << size) - 1) << off);
                for (int i = 0; i < 4; i++) e.wd[8*i +: 8] = wd[8*(i % size) +: 8];
            end
            if (to) begin
                e.is_fault = 1'b1;
                e.code     = 2'd3;
            end else if (st) begin
                e.ld = '0;
            end else begin
                v = ({32'd0, rd} >> (8 * off)) & ((64'd1 << (8 * size)) - 64'd1);
                if (!f3[2] && size < 4 && v[8*size-1]) v = v - (64'd1 << (8 * size));
                e.ld = v[31:0];
            end
        end
        return e;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (mem_req) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL bus_unexpected_req: got mem_req=1 expected no request (t=%0t)", $time);
                end else begin
                    chk("mem_we", 32'(mem_we), 32'(sb_q[0].we));
                    chk("mem_addr", mem_addr, sb_q[0].addr);
                    chk("mem_wstrb", 32'(mem_wstrb), 32'(sb_q[0].strb));
                    if (sb_q[0].we) chk("mem_wdata", mem_wdata, sb_q[0].wd);
                end
            end
            if (done || fault) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_response: got done=%0b fault=%0b expected none (t=%0t)",
                             done, fault, $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_kind", 32'({done, fault}), e.is_fault ? 32'd1 : 32'd2);
                    chk("fault_code", 32'(fault_code), 32'(e.code));
                    if (done) chk("load_data", load_data, e.ld);
                end
            end
        end
    end

    // Issues one instruction in the current (IDLE) cycle, plays the memory
    // with an ack after dly wait cycles (dly<0: never), and checks timing.
    task automatic run_txn(input bit ld, input bit st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int dly);
        exp_t e;
        int   exp_end, exp_req, exp_stall;
        int   n_req, n_stall, n_resp, end_c;
        n_req = 0; n_stall = 0; n_resp = 0; end_c = -1;
        e = model(ld, st, f3, a, wd, rd, dly < 0, model_ld);
        model_ld = e.ld;
        if (e.is_fault && e.code != 2'd3) begin
            exp_end = 1; exp_req = 0; exp_stall = 0;
        end else if (e.is_fault) begin
            exp_end = TO + 1; exp_req = TO; exp_stall = TO;
        end else begin
            exp_end = dly + 2; exp_req = dly + 1; exp_stall = dly + 1;
        end
        start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd;
        sb_q.push_back(e);
        #1 chk("stall_cycle0", 32'(stall), 32'd1);
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (mem_req) n_req++;
            if (stall) n_stall++;
            if (done || fault) begin
                n_resp++;
                if (end_c < 0) end_c = c;
            end
            // The core keeps start asserted for as long as it is stalled.
            if (!stall) start = 1'b0;
            mem_ack   = mem_req && dly >= 0 && (c - 1) == dly;
            mem_rdata = mem_ack ? rd : $urandom();
            if (end_c >= 0 && c >= end_c + 2) break;
        end
        mem_ack = 1'b0;
        start   = 1'b0;
        if (end_c < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL no_response: got no done/fault within 60 cycles expected one at cycle %0d", exp_end);
            sb_q.delete();
        end else begin
            chk("end_cycle", 32'(end_c), 32'(exp_end));
        end
        chk("req_cycles", 32'(n_req), 32'(exp_req));
        chk("stall_cycles", 32'(n_stall), 32'(exp_stall));
        chk("responses", 32'(n_resp), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        int          r, dly;
        bit          ld, st;
        logic [2:0]  f3;
        logic [31:0] a;

        // Reset state
        #12;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_fault_code", 32'(fault_code), 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // LB / LBU at 0x103
        run_txn(1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0);
        chk("lb_value", load_data, 32'hFFFF_FF80);
        run_txn(1, 0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0);
        chk("lbu_value", load_data, 32'h0000_0080);

        // SH at 0x202 with three wait cycles
        run_txn(0, 1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 3);
        chk("sh_clears_load_data", load_data, 32'h0);

        // Misaligned LW, illegal load funct3
        run_txn(1, 0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 0);
        chk("lw_misaligned_code", 32'(fault_code), 32'd1);
        run_txn(1, 0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0);
        chk("ld_illegal_code", 32'(fault_code), 32'd2);

        // SW timeout, then a late ack in IDLE
        run_txn(0, 1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, -1);
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        @(posedge clk); #1 mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_ack_no_done", 32'(done), 32'd0);
            chk("late_ack_no_req", 32'(mem_req), 32'd0);
            @(posedge clk); #1;
        end
        chk("timeout_code_held", 32'(fault_code), 32'd3);

        // Both type strobes set
        run_txn(1, 1, 3'b010, 32'h0000_0400, 32'h0, 32'h0, 0);
        chk("both_types_code", 32'(fault_code), 32'd2);

        // Leave a non-zero load result, then reset in the middle of REQ
        run_txn(1, 0, 3'b010, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1);
        chk("lw_value", load_data, 32'hDEAD_BEEF);
        e = model(1, 0, 3'b010, 32'h0000_0044, 32'h0, 32'h0, 1'b1, model_ld);
        start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0044;
        sb_q.push_back(e);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_req", 32'(mem_req), 32'd1);
        #1 rst_n = 1'b0; start = 1'b0;
        #1;
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_load_data", load_data, 32'd0);
        sb_q.delete();
        model_ld = '0;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(1, 0, 3'b101, 32'h0000_0002, 32'h0, 32'hF00D_0000, 0);
        chk("lhu_value", load_data, 32'h0000_F00D);

        // Randomized instructions
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                ld = 1; st = 1;
            end else if (r == 1) begin
                ld = 0; st = 0;
            end else begin
                ld = r[0]; st = !r[0];
            end
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                if (st) f3 = 3'($urandom_range(0, 2));
                else begin
                    r  = $urandom_range(0, 4);
                    f3 = (r < 3) ? 3'(r) : 3'(r + 1);
                end
            end
            a = $urandom();
            if ($urandom_range(0, 1) == 1) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            dly = ($urandom_range(0, 19) == 0) ? -1 : $urandom_range(0, 4);
            run_txn(ld, st, f3, a, $urandom(), $urandom(), dly);
        end

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
